// File: rtl/mcp3x08_pkg.sv
// Shared types and constants for the MCP3008/MCP3208 scanning controller.
// Frame geometry helpers live here so every file agrees on bit counts.
package mcp3x08_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HIGH
    } scan_state_t;

    localparam logic START_BIT       = 1'b1;
    localparam int   DATA_FIRST_EDGE = 7;

    function automatic int frame_bits(input int res);
        return 7 + res;
    endfunction

endpackage

// File: rtl/mcp3x08_tick_gen.sv
// SCLK half-period timebase for the scanning ADC controller.
// Restarts on clear so every frame begins with a full setup period.
module mcp3x08_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic half_tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign half_tick = (cnt == CW'(CLK_DIV - 1));

    // free-running modulo-CLK_DIV counter, restarted at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || half_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mcp3x08_scan_adc.sv
// Round-robin scanning controller for MCP3008/MCP3208 SPI ADCs.
// Streams each sample and keeps the latest result per channel.
module mcp3x08_scan_adc
    import mcp3x08_pkg::*;
#(
    parameter int CLK_DIV  = 50,
    parameter int RES_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [7:0]            ch_mask,
    input  logic                  diff_mode,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_din,
    input  logic                  spi_dout,
    output logic                  busy,
    output logic                  sample_valid,
    output logic [2:0]            sample_ch,
    output logic [RES_BITS-1:0]   sample_data,
    output logic [8*RES_BITS-1:0] ch_data
);

    localparam int FB = frame_bits(RES_BITS);
    localparam int HW = $clog2(2 * FB);

    scan_state_t         state;
    scan_state_t         state_n;
    logic                half_tick;
    logic                setup_entry;
    logic                last_half;
    logic [HW-1:0]       hcnt;
    logic [HW-1:0]       edge_idx;
    logic [2:0]          ptr;
    logic [2:0]          cur_ch;
    logic [2:0]          pick;
    logic [4:0]          tx;
    logic [RES_BITS-1:0] rx;

    assign setup_entry = (state_n == S_CS_SETUP) && (state != S_CS_SETUP);
    assign last_half   = half_tick && (hcnt == HW'(2 * FB - 1));
    assign edge_idx    = hcnt >> 1;
    assign spi_din     = tx[4];

    mcp3x08_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (setup_entry),
        .half_tick(half_tick)
    );

    // next-state logic for the frame sequencer
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     if (en && |ch_mask) state_n = S_CS_SETUP;
            S_CS_SETUP: if (half_tick) state_n = S_SHIFT;
            S_SHIFT:    if (last_half) state_n = S_CS_HIGH;
            S_CS_HIGH: begin
                if (half_tick) begin
                    state_n = (en && |ch_mask) ? S_CS_SETUP : S_IDLE;
                end
            end
            default:    state_n = S_IDLE;
        endcase
    end

    // next enabled channel at or above ptr, wrapping 7 to 0
    always_comb begin
        pick = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[ptr + 3'(i)]) pick = ptr + 3'(i);
        end
    end

    // state register with registered chip select and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            spi_cs_n <= 1'b1;
        end else begin
            state    <= state_n;
            busy     <= (state_n != S_IDLE);
            spi_cs_n <= !((state_n == S_CS_SETUP) || (state_n == S_SHIFT));
        end
    end

    // channel pointer: latch pick at frame start, rewind when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            cur_ch <= '0;
        end else if (setup_entry) begin
            cur_ch <= pick;
            ptr    <= pick + 3'd1;
        end else if (state_n == S_IDLE) begin
            ptr <= '0;
        end
    end

    // SCLK generation, DIN shift-out on falls, DOUT capture on rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt    <= '0;
            spi_clk <= 1'b0;
            tx      <= '0;
            rx      <= '0;
        end else if (setup_entry) begin
            hcnt    <= '0;
            spi_clk <= 1'b0;
            tx      <= {START_BIT, !diff_mode, pick};
            rx      <= '0;
        end else if ((state == S_SHIFT) && half_tick) begin
            hcnt    <= hcnt + 1'b1;
            spi_clk <= !spi_clk;
            if (!spi_clk) begin
                if (edge_idx >= HW'(DATA_FIRST_EDGE)) begin
                    rx <= {rx[RES_BITS-2:0], spi_dout};
                end
            end else begin
                tx <= {tx[3:0], 1'b0};
            end
        end
    end

    // deliver the finished conversion as the frame closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            ch_data      <= '0;
        end else begin
            sample_valid <= 1'b0;
            if ((state == S_SHIFT) && last_half) begin
                sample_valid <= 1'b1;
                sample_ch    <= cur_ch;
                sample_data  <= rx;
                ch_data[int'(cur_ch) * RES_BITS +: RES_BITS] <= rx;
            end
        end
    end

endmodule
